block_data_memory: RTL and testbench

//  Word-organised backing data memory directly downstream of the data cache.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_latency_ctr.sv | 33 +++
 rtl/block_data_memory.sv | 166 ++++++++++++++++
 tb/tb_block_data_memory.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared widths, latency constants and FSM state type for the block data memory.
// The cache imports this package so both sides agree on interface widths.
package dmem_pkg;

  localparam int DMEM_ADDR_W        = 6;
  localparam int DMEM_BLOCK_W       = 32;
  localparam int DMEM_CNT_W         = 4;
  localparam int DMEM_ACCESS_CYCLES = 5;
  localparam int DMEM_STAT_W        = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } dmem_state_e;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [DMEM_STAT_W-1:0] sat_inc(input logic [DMEM_STAT_W-1:0] value);
    if (value == {DMEM_STAT_W{1'b1}}) begin
      return value;
    end else begin
      return value + {{(DMEM_STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/dmem_latency_ctr.sv
// Loadable down-counter that paces the memory access latency.
// The zero flag marks the last busy cycle of an access.
module dmem_latency_ctr
  import dmem_pkg::*;
#(
  parameter int CNT_W = DMEM_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_zero
);

  logic [CNT_W-1:0] count_r;

  // Load takes priority over decrement; the count never underflows.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign is_zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/block_data_memory.sv
// Word-organised backing memory behind the data cache with a fixed multi-cycle latency.
// Defining DMEM_STATS_EN adds saturating rd_count/wr_count completion counters.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W        = DMEM_ADDR_W,
  parameter int BLOCK_W       = DMEM_BLOCK_W,
  parameter int ACCESS_CYCLES = DMEM_ACCESS_CYCLES
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  mem_address,
  input  logic [BLOCK_W-1:0] mem_writedata,
  output logic [BLOCK_W-1:0] mem_readdata,
  output logic               busywait
`ifdef DMEM_STATS_EN
  ,
  output logic [DMEM_STAT_W-1:0] rd_count,
  output logic [DMEM_STAT_W-1:0] wr_count
`endif
);

  localparam int   DEPTH        = 1 << ADDR_W;
  localparam logic SINGLE_CYCLE = (ACCESS_CYCLES == 1) ? 1'b1 : 1'b0;
  // The IDLE cycle already counts as the first busy cycle, so BUSY lasts
  // ACCESS_CYCLES-1 cycles and the counter holds the BUSY cycles still to go after the current one.
  localparam logic [DMEM_CNT_W-1:0] LOAD_VAL =
    (ACCESS_CYCLES >= 2) ? DMEM_CNT_W'(ACCESS_CYCLES - 2) : {DMEM_CNT_W{1'b0}};

  if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15)) begin : g_bad_latency
    $error("block_data_memory: ACCESS_CYCLES must be within 1..15");
  end

  dmem_state_e        state_r;
  logic [BLOCK_W-1:0] mem_r [DEPTH];
  logic [BLOCK_W-1:0] readdata_r;
  logic               req_s;
  logic               load_s;
  logic               dec_s;
  logic               commit_s;
  logic               cnt_zero_s;

  assign req_s = mem_read | mem_write;

  dmem_latency_ctr #(
    .CNT_W (DMEM_CNT_W)
  ) u_latency_ctr (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load_s),
    .load_val (LOAD_VAL),
    .dec      (dec_s),
    .is_zero  (cnt_zero_s)
  );

  // Per-state counter control and the single-cycle commit strobe.
  always_comb begin
    load_s   = 1'b0;
    dec_s    = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (SINGLE_CYCLE) begin
            commit_s = 1'b1;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      BUSY: begin
        if (!req_s) begin
          commit_s = 1'b0;
        end else if (cnt_zero_s) begin
          commit_s = 1'b1;
        end else begin
          dec_s = 1'b1;
        end
      end
      RESPOND: begin
        commit_s = 1'b0;
      end
      default: begin
        commit_s = 1'b0;
      end
    endcase
  end

  // busywait must react in the same cycle a request appears, hence combinational.
  always_comb begin
    if (RESET) begin
      busywait = 1'b0;
    end else if ((state_r == IDLE) || (state_r == BUSY)) begin
      busywait = req_s;
    end else begin
      busywait = 1'b0;
    end
  end

  // Access FSM, storage array and read-data register; write wins over read at commit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      readdata_r <= {BLOCK_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {BLOCK_W{1'b0}};
      end
    end else begin
      if (commit_s) begin
        if (mem_write) begin
          mem_r[mem_address] <= mem_writedata;
        end else begin
          readdata_r <= mem_r[mem_address];
        end
      end
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_r <= SINGLE_CYCLE ? RESPOND : BUSY;
          end
        end
        BUSY: begin
          if (!req_s) begin
            state_r <= IDLE;
          end else if (commit_s) begin
            state_r <= RESPOND;
          end
        end
        RESPOND: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign mem_readdata = readdata_r;

`ifdef DMEM_STATS_EN
  logic [DMEM_STAT_W-1:0] rd_count_r;
  logic [DMEM_STAT_W-1:0] wr_count_r;

  // Only committed accesses count; aborts never raise commit_s.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_count_r <= {DMEM_STAT_W{1'b0}};
      wr_count_r <= {DMEM_STAT_W{1'b0}};
    end else if (commit_s) begin
      if (mem_write) begin
        wr_count_r <= sat_inc(wr_count_r);
      end else begin
        rd_count_r <= sat_inc(rd_count_r);
      end
    end else begin
      rd_count_r <= rd_count_r;
      wr_count_r <= wr_count_r;
    end
  end

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: a 5-cycle instance and a 1-cycle instance
// share stimulus; sel chooses which one is observed. Stats checks need DMEM_STATS_EN.
module tb_block_data_memory;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] rdata0, rdata1, obs_rdata;
  logic        bw0, bw1, obs_bw;
  logic        sel;
`ifdef DMEM_STATS_EN
  logic [15:0] rc0, wc0, rc1, wc1;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [64];
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  assign obs_bw    = sel ? bw1 : bw0;
  assign obs_rdata = sel ? rdata1 : rdata0;

  block_data_memory #(.ADDR_W(6), .BLOCK_W(32), .ACCESS_CYCLES(5)) dut0 (
    .CLK(CLK), .RESET(RESET), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(rdata0), .busywait(bw0)
`ifdef DMEM_STATS_EN
    , .rd_count(rc0), .wr_count(wc0)
`endif
  );

  block_data_memory #(.ADDR_W(6), .BLOCK_W(32), .ACCESS_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(rdata1), .busywait(bw1)
`ifdef DMEM_STATS_EN
    , .rd_count(rc1), .wr_count(wc1)
`endif
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    exp_q.delete();
  endtask

  // Called just after a rising edge. Drives one access, counts busy cycles,
  // then pops the scoreboard on the response cycle of a read.
  task automatic run_access(input logic wr, input logic rd, input logic [5:0] addr,
                            input logic [31:0] wd, input logic release_req, output int busy);
    logic [31:0] exp;
    mem_write = wr; mem_read = rd; mem_address = addr; mem_writedata = wd;
    if (rd && !wr) exp_q.push_back(model_mem[addr]);
    busy = 0;
    @(negedge CLK);
    while ((obs_bw === 1'b1) && (busy < 40)) begin
      busy++;
      @(negedge CLK);
    end
    if (busy >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL access_timeout: busywait still high after %0d cycles, required low", busy);
    end
    if (wr) begin
      model_mem[addr] = wd;
    end else if (rd) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (obs_rdata !== exp) begin
        n_fail++;
        $display("FAIL read_data @%h: got %h, expected %h", addr, obs_rdata, exp);
      end
    end
    @(posedge CLK); #1;
    if (release_req) begin
      mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    RESET = 1'b1; mem_write = 1'b0; mem_read = 1'b1;
    mem_address = 6'h05; mem_writedata = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (bw0 !== 1'b0 || bw1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_busywait: got %b/%b, expected 0/0", bw0, bw1);
    end
    n_checks++;
    if (rdata0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata: got %h, expected 00000000", rdata0);
    end
`ifdef DMEM_STATS_EN
    n_checks++;
    if (rc0 !== 16'h0 || wc0 !== 16'h0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d, expected 0/0", rc0, wc0);
    end
`endif
    @(posedge CLK); #1;
    RESET = 1'b0; mem_read = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bw0 !== 1'b0) begin
      n_fail++; $display("FAIL idle_busywait: got %b, expected 0", bw0);
    end
    @(posedge CLK); #1;
    clear_model();
  endtask

  task automatic test_read_after_reset();
    int busy;
    run_access(1'b0, 1'b1, 6'h05, 32'h0, 1'b1, busy);
    n_checks++;
    if (busy !== 5) begin
      n_fail++; $display("FAIL read_latency: got %0d busy cycles, expected 5", busy);
    end
  endtask

  task automatic test_write_read();
    int busy;
    logic [5:0] addrs [3];
    addrs[0] = 6'h00; addrs[1] = 6'h3F; addrs[2] = 6'h15;
    run_access(1'b1, 1'b0, 6'h2A, 32'hDEADBEEF, 1'b1, busy);
    n_checks++;
    if (busy !== 5) begin
      n_fail++; $display("FAIL write_latency: got %0d busy cycles, expected 5", busy);
    end
    run_access(1'b0, 1'b1, 6'h2A, 32'h0, 1'b1, busy);
    n_checks++;
    if (busy !== 5) begin
      n_fail++; $display("FAIL read_latency_2A: got %0d busy cycles, expected 5", busy);
    end
    for (int i = 0; i < 3; i++) run_access(1'b1, 1'b0, addrs[i], $urandom, 1'b1, busy);
    for (int i = 0; i < 3; i++) run_access(1'b0, 1'b1, addrs[i], 32'h0, 1'b1, busy);
  endtask

  task automatic test_back_to_back();
    int busy;
    run_access(1'b1, 1'b0, 6'h11, 32'hCAFEF00D, 1'b1, busy);
    run_access(1'b1, 1'b0, 6'h10, 32'h11112222, 1'b0, busy);
    n_checks++;
    if (busy !== 5) begin
      n_fail++; $display("FAIL b2b_write_latency: got %0d, expected 5", busy);
    end
    // Read raised on the write's response edge: no extra idle gap allowed.
    run_access(1'b0, 1'b1, 6'h11, 32'h0, 1'b1, busy);
    n_checks++;
    if (busy !== 5) begin
      n_fail++; $display("FAIL b2b_read_latency: got %0d, expected 5", busy);
    end
    run_access(1'b0, 1'b1, 6'h10, 32'h0, 1'b1, busy);
  endtask

  task automatic test_abort();
    int busy;
    run_access(1'b1, 1'b0, 6'h03, 32'h0BAD0003, 1'b1, busy);
    run_access(1'b0, 1'b1, 6'h2A, 32'h0, 1'b1, busy);
    mem_write = 1'b1; mem_address = 6'h03; mem_writedata = 32'h12345678;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    mem_write = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bw0 !== 1'b0) begin
      n_fail++; $display("FAIL abort_busywait: got %b, expected 0", bw0);
    end
    n_checks++;
    if (rdata0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL abort_readdata: got %h, expected deadbeef", rdata0);
    end
    @(posedge CLK); #1;
    run_access(1'b0, 1'b1, 6'h03, 32'h0, 1'b1, busy);
  endtask

  task automatic test_reset_mid_read();
    int busy;
    mem_read = 1'b1; mem_address = 6'h2A;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (bw0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_busywait: got %b, expected 0", bw0);
    end
    @(posedge CLK); #1;
    RESET = 1'b0; mem_read = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (rdata0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_readdata: got %h, expected 00000000", rdata0);
    end
`ifdef DMEM_STATS_EN
    n_checks++;
    if (rc0 !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_stats: got %0d, expected 0", rc0);
    end
`endif
    @(posedge CLK); #1;
    clear_model();
    run_access(1'b0, 1'b1, 6'h2A, 32'h0, 1'b1, busy);
  endtask

  task automatic test_single_cycle();
    int busy;
    int total;
    sel = 1'b1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    clear_model();
    total = 0;
    run_access(1'b1, 1'b0, 6'h01, 32'hA1A1A1A1, 1'b1, busy); total += busy;
    run_access(1'b1, 1'b0, 6'h02, 32'hB2B2B2B2, 1'b1, busy); total += busy;
    run_access(1'b0, 1'b1, 6'h3F, 32'h0, 1'b1, busy); total += busy;
    run_access(1'b0, 1'b1, 6'h01, 32'h0, 1'b1, busy); total += busy;
    run_access(1'b0, 1'b1, 6'h02, 32'h0, 1'b1, busy); total += busy;
    n_checks++;
    if (total !== 5) begin
      n_fail++; $display("FAIL single_cycle_latency: got %0d busy cycles over 5 accesses, expected 5", total);
    end
`ifdef DMEM_STATS_EN
    n_checks++;
    if (rc1 !== 16'd3 || wc1 !== 16'd2) begin
      n_fail++; $display("FAIL stats_count: got rd=%0d wr=%0d, expected rd=3 wr=2", rc1, wc1);
    end
`endif
    run_access(1'b1, 1'b1, 6'h04, 32'hC3C3C3C3, 1'b1, busy);
    n_checks++;
    if (busy !== 1) begin
      n_fail++; $display("FAIL both_req_latency: got %0d, expected 1", busy);
    end
    n_checks++;
    if (obs_rdata !== 32'hB2B2B2B2) begin
      n_fail++; $display("FAIL both_req_readdata: got %h, expected b2b2b2b2", obs_rdata);
    end
`ifdef DMEM_STATS_EN
    n_checks++;
    if (rc1 !== 16'd3 || wc1 !== 16'd3) begin
      n_fail++; $display("FAIL both_req_stats: got rd=%0d wr=%0d, expected rd=3 wr=3", rc1, wc1);
    end
`endif
    run_access(1'b0, 1'b1, 6'h04, 32'h0, 1'b1, busy);
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_reset_mid_read();
    test_single_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
